// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for multicycle_control
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemToRead;
    logic       MemToWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       mem_timeout;
    logic [3:0] state;

    // Controller side: consumes opcode/mem_ready, drives all enables and selects.
    modport master (
        input  opcode, mem_ready,
        output PCWrite, Branch, PCSrc, IorD, MemToRead, MemToWrite, IRWrite,
               RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               mem_timeout, state
    );

    // Datapath side: supplies opcode/mem_ready, receives the controls.
    modport slave (
        output opcode, mem_ready,
        input  PCWrite, Branch, PCSrc, IorD, MemToRead, MemToWrite, IRWrite,
               RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               mem_timeout, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM; ILLEGAL_TRAP_EN selects trapping on unknown opcodes
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // A zero timeout disables the abort path entirely; the counter may then wrap harmlessly.
    localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_state;
    logic        abort;

    // State register and memory-wait counter; reset drops straight back to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing, memory-wait abort and counter update.
    always_comb begin
        state_d   = state_q;
        abort     = 1'b0;
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

        case (state_q)
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BEQEX:   state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:    state_d = S_TRAP;
`else
            S_TRAP:    state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase

        // Give up on a stuck access; an aborted MEMRD never reaches MEMWB, so no write happens.
        if (TO_EN && mem_state && !bus.mem_ready && (cnt_q == TO_LAST)) begin
            abort   = 1'b1;
            state_d = S_FETCH;
        end

        // Count consecutive wait cycles only while sitting in the same memory state.
        if (mem_state && !bus.mem_ready && (state_d == state_q)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    logic       pc_write, branch, iord, mem_rd, mem_wr, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b, alu_op;

    // Moore decode of the state register; FETCH also gates the PC/IR loads with mem_ready.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB:  reg_write = 1'b1;
            S_JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Everything is held low while reset is asserted, including FETCH's read strobe.
    assign bus.PCWrite     = pc_write   & ~reset;
    assign bus.Branch      = branch     & ~reset;
    assign bus.PCSrc       = pc_src     & {2{~reset}};
    assign bus.IorD        = iord       & ~reset;
    assign bus.MemToRead   = mem_rd     & ~reset;
    assign bus.MemToWrite  = mem_wr     & ~reset;
    assign bus.IRWrite     = ir_write   & ~reset;
    assign bus.RegDst      = reg_dst    & ~reset;
    assign bus.MemToReg    = mem_to_reg & ~reset;
    assign bus.RegWrite    = reg_write  & ~reset;
    assign bus.ALUSrcA     = alu_src_a  & ~reset;
    assign bus.ALUSrcB     = alu_src_b  & {2{~reset}};
    assign bus.ALUOp       = alu_op     & {2{~reset}};
    assign bus.mem_timeout = abort      & ~reset;
    assign bus.state       = state_q    & {4{~reset}};

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against an instruction-level model
module tb_multicycle_control;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: each opcode maps to the list of states it walks after DECODE.
    int  m_state = 0;
    int  m_wait  = 0;
    int  m_path[$];
    bit  m_leave;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_wait  = 0;
            m_path.delete();
        end else begin
            m_leave = 1'b1;
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !bus.mem_ready) begin
                m_leave = 1'b0;
                if (m_wait == TO - 1) begin
                    m_state = 0;
                    m_wait  = 0;
                    m_path.delete();
                end else begin
                    m_wait++;
                end
            end
            if (m_leave) begin
                m_wait = 0;
                if (m_state == 12) begin
                    m_state = 12;
                end else if (m_state == 0) begin
                    m_state = 1;
                end else begin
                    if (m_state == 1) begin
                        case (bus.opcode)
                            6'b000000: m_path = {6, 7};
                            6'b100011: m_path = {2, 3, 4};
                            6'b101011: m_path = {2, 5};
                            6'b000100: m_path = {8};
                            6'b001000: m_path = {9, 10};
                            6'b000010: m_path = {11};
`ifdef ILLEGAL_TRAP_EN
                            default:   m_path = {12};
`else
                            default:   m_path.delete();
`endif
                        endcase
                    end
                    if (m_path.size() > 0) m_state = m_path.pop_front();
                    else                   m_state = 0;
                end
            end
        end
    end

    // Control word the spec's per-state table demands; order matches dut_word below.
    function automatic logic [16:0] exp_word(input int s, input logic rdy, input int w);
        logic       pcw, br, iord, mr, mw, irw, rd, m2r, rw, asa, to;
        logic [1:0] pcs, asb, aop;
        {pcw, br, iord, mr, mw, irw, rd, m2r, rw, asa, to} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin iord = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        to = (s == 0 || s == 3 || s == 5) && !rdy && (w == TO - 1);
        return {pcw, br, pcs, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, to};
    endfunction

    logic [16:0] dut_word;
    assign dut_word = {bus.PCWrite, bus.Branch, bus.PCSrc, bus.IorD, bus.MemToRead,
                       bus.MemToWrite, bus.IRWrite, bus.RegDst, bus.MemToReg, bus.RegWrite,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.mem_timeout};

    logic [63:0] trace_word = '0;
    int          rw_cnt = 0;
    int          to_cnt = 0;

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("state_in_reset", 64'(bus.state), 64'd0);
            chk("outputs_in_reset", 64'(dut_word), 64'd0);
        end else begin
            chk("state", 64'(bus.state), 64'(m_state));
            chk("outputs", 64'(dut_word), 64'(exp_word(m_state, bus.mem_ready, m_wait)));
        end
        trace_word = {trace_word[59:0], bus.state};
        if (bus.RegWrite)    rw_cnt++;
        if (bus.mem_timeout) to_cnt++;
    end

    task automatic step(input logic [5:0] op, input logic rdy);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_stats();
        trace_word = '0;
        rw_cnt     = 0;
        to_cnt     = 0;
    endtask

    initial begin
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // R-type with zero-wait memory, plus literal reset-release pin.
        do_reset();
        clear_stats();
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release_state", 64'(bus.state), 64'd0);
        chk("release_memread", 64'(bus.MemToRead), 64'd1);
        @(posedge clk);
        #1;
        repeat (4) step(6'b000000, 1'b1);
        chk("rtype_trace", trace_word, 64'h01670);
        chk("rtype_regwrite", 64'(rw_cnt), 64'd1);

        // lw with three wait cycles in MEMRD.
        do_reset();
        clear_stats();
        repeat (3) step(6'b100011, 1'b1);
        repeat (3) step(6'b100011, 1'b0);
        repeat (3) step(6'b100011, 1'b1);
        chk("lw_trace", trace_word, 64'h012333340);
        chk("lw_regwrite", 64'(rw_cnt), 64'd1);

        // beq.
        do_reset();
        clear_stats();
        repeat (4) step(6'b000100, 1'b1);
        chk("beq_trace", trace_word, 64'h0180);

        // addi and j.
        do_reset();
        clear_stats();
        repeat (5) step(6'b001000, 1'b1);
        chk("addi_trace", trace_word, 64'h019A0);
        do_reset();
        clear_stats();
        repeat (4) step(6'b000010, 1'b1);
        chk("j_trace", trace_word, 64'h01B0);

        // sw with memory never ready: abort after TO cycles, no register write.
        do_reset();
        clear_stats();
        repeat (3) step(6'b101011, 1'b1);
        repeat (4) step(6'b101011, 1'b0);
        step(6'b101011, 1'b1);
        chk("sw_abort_trace", trace_word, 64'h01255550);
        chk("sw_abort_pulses", 64'(to_cnt), 64'd1);
        chk("sw_abort_regwrite", 64'(rw_cnt), 64'd0);

        // Fetch stall long enough to abort and restart the fetch.
        do_reset();
        clear_stats();
        repeat (4) step(6'b000000, 1'b0);
        step(6'b000000, 1'b1);
        chk("fetch_abort_trace", trace_word, 64'h00000);
        chk("fetch_abort_pulses", 64'(to_cnt), 64'd1);

        // Unknown opcode.
        do_reset();
        clear_stats();
        repeat (5) step(6'b111111, 1'b1);
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_trace", trace_word, 64'h01CCC);
`else
        chk("illegal_trace", trace_word, 64'h01010);
`endif

        // Reset asserted while stalled in MEMRD: no write, clean FETCH after release.
        do_reset();
        repeat (3) step(6'b100011, 1'b1);
        step(6'b100011, 1'b0);
        clear_stats();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("midrd_reset_memread", 64'(bus.MemToRead), 64'd0);
        chk("midrd_reset_state", 64'(bus.state), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("midrd_release_state", 64'(bus.state), 64'd0);
        chk("midrd_release_memread", 64'(bus.MemToRead), 64'd1);
        chk("midrd_regwrite", 64'(rw_cnt), 64'd0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
